// File: rtl/a2d_scan_seq.sv
// -----------------------------------------------------------------------------
// a2d_scan_seq
//
// Purpose:
//   Walks the IR line sensors through one A2D conversion each per scan.
//   When `go` arrives in IDLE, the sequencer turns on the IR emitters and
//   waits a settle interval. It then requests one conversion per channel, in
//   order 0..NUM_CH-1, and captures each 12-bit result into a shadow bank.
//   After the last channel is captured, the whole bank is copied to `sensors`
//   in a single cycle. Steering logic therefore never sees a mix of old and
//   new readings. A per-conversion watchdog abandons the scan, and sets the
//   sticky `err` flag, if the A2D never reports completion.
//
// Parameters:
//   NUM_CH   channels per scan (1..8)
//   SETTLE   emitter settle time in clk cycles before the first conversion (>= 1)
//   TIMEOUT  max clk cycles spent waiting for each `cnv_cmplt` (>= 2)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   go         in   start a scan (looked at only while idle)
//   cnv_cmplt  in   A2D conversion done; the A2D drops it on `strt_cnv`
//   res        in   12-bit A2D result, valid while `cnv_cmplt` is high
//   strt_cnv   out  one-cycle conversion request
//   chnnl      out  channel select, held from `strt_cnv` until capture
//   IR_en      out  IR emitter enable (registered)
//   busy       out  high whenever not idle
//   scan_done  out  one-cycle pulse in the cycle `sensors` is updated
//   err        out  sticky watchdog flag, cleared by the next accepted `go`
//   sensors    out  committed results, channel i at [12*i+11:12*i]
//
// A2D handshake:
//   `strt_cnv` is a single-cycle request, qualified by `chnnl`. The A2D clears
//   `cnv_cmplt` on the same edge that ends the request cycle. It raises
//   `cnv_cmplt` again, with `res` valid, once the conversion is finished. So
//   any high `cnv_cmplt` seen in WAIT belongs to the current request. The
//   sequencer never issues a new request before the current one is captured
//   or abandoned.
// -----------------------------------------------------------------------------
module a2d_scan_seq #(
    parameter int NUM_CH  = 8,
    parameter int SETTLE  = 1024,
    parameter int TIMEOUT = 2048
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic                  cnv_cmplt,
    input  logic [11:0]           res,
    output logic                  strt_cnv,
    output logic [2:0]            chnnl,
    output logic                  IR_en,
    output logic                  busy,
    output logic                  scan_done,
    output logic                  err,
    output logic [12*NUM_CH-1:0]  sensors
);

    // The one cycle counter serves both the settle interval and the watchdog.
    // It is cleared on entry to SETTLE and to WAIT, so it never wraps.
    localparam int MAX_CNT = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
    localparam logic [2:0]    LAST_CH      = 3'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_nxt;
    logic [2:0]           chnnl_nxt;
    logic                 ir_en_nxt;
    logic                 err_nxt;
    logic                 capture;
    logic                 commit;
    logic [12*NUM_CH-1:0] shadow;
    logic [12*NUM_CH-1:0] shadow_nxt;

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        chnnl_nxt = chnnl;
        ir_en_nxt = IR_en;
        err_nxt   = err;
        capture   = 1'b0;
        commit    = 1'b0;
        strt_cnv  = 1'b0;
        scan_done = 1'b0;
        busy      = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (go) begin
                    state_nxt = S_SETTLE;
                    ir_en_nxt = 1'b1;
                    err_nxt   = 1'b0;
                    chnnl_nxt = 3'd0;
                    cnt_nxt   = '0;
                end
            end

            S_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_nxt = S_START;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            S_START: begin
                strt_cnv  = 1'b1;
                cnt_nxt   = '0;
                state_nxt = S_WAIT;
            end

            S_WAIT: begin
                // A completion takes priority over the watchdog when both
                // happen in the same cycle.
                if (cnv_cmplt) begin
                    capture = 1'b1;
                    if (chnnl == LAST_CH) begin
                        commit    = 1'b1;
                        ir_en_nxt = 1'b0;
                        state_nxt = S_DONE;
                    end else begin
                        chnnl_nxt = chnnl + 3'd1;
                        state_nxt = S_START;
                    end
                end else if (cnt == TIMEOUT_LAST) begin
                    // Abandon the scan. The previous `sensors` stay visible.
                    err_nxt   = 1'b1;
                    ir_en_nxt = 1'b0;
                    chnnl_nxt = 3'd0;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            S_DONE: begin
                scan_done = 1'b1;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Shadow bank write
    // -------------------------------------------------------------------------
    // The commit copies shadow_nxt rather than shadow. The last channel's
    // result therefore reaches `sensors` in the same edge that captures it.
    always_comb begin
        shadow_nxt = shadow;
        if (capture) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (chnnl == 3'(i)) begin
                    shadow_nxt[12*i +: 12] = res;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            chnnl   <= 3'd0;
            IR_en   <= 1'b0;
            err     <= 1'b0;
            shadow  <= '0;
            sensors <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            chnnl  <= chnnl_nxt;
            IR_en  <= ir_en_nxt;
            err    <= err_nxt;
            shadow <= shadow_nxt;
            if (commit) begin
                sensors <= shadow_nxt;
            end
        end
    end

endmodule

// File: tb/tb_a2d_scan_seq.sv
// -----------------------------------------------------------------------------
// tb_a2d_scan_seq
//
// Bench for a2d_scan_seq with NUM_CH=8, SETTLE=16, TIMEOUT=64. A behavioural
// A2D model answers each `strt_cnv` after a programmable delay. The result
// for a channel is base + step*ch, where base is `lo` for ch0-3 and `hi` for
// ch4-7. One channel can be told never to complete. Cycle numbers are
// relative to the cycle in which `go` is high at the rising edge.
// -----------------------------------------------------------------------------
module tb_a2d_scan_seq;

    localparam int NUM_CH  = 8;
    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 64;
    localparam int W       = 12 * NUM_CH;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic         go;
    logic         cnv_cmplt;
    logic [11:0]  res;
    logic         strt_cnv;
    logic [2:0]   chnnl;
    logic         IR_en;
    logic         busy;
    logic         scan_done;
    logic         err;
    logic [W-1:0] sensors;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    a2d_scan_seq #(
        .NUM_CH  (NUM_CH),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .go        (go),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .IR_en     (IR_en),
        .busy      (busy),
        .scan_done (scan_done),
        .err       (err),
        .sensors   (sensors)
    );

    // ---------------- A2D model ----------------
    // With a delay of D, `cnv_cmplt` rises in the cycle D after the
    // `strt_cnv` cycle. The model is not reset by rst_n, so a conversion that
    // was in flight during a reset still completes later.
    int          m_delay    = 1;
    int          m_never_ch = -1;
    logic [11:0] m_lo       = '0;
    logic [11:0] m_hi       = '0;
    logic [11:0] m_step     = '0;
    int          m_cnt      = 0;
    logic [2:0]  m_ch       = '0;

    always @(negedge clk) begin
        if (strt_cnv) begin
            cnv_cmplt = 1'b0;
            m_ch      = chnnl;
            m_cnt     = (int'(chnnl) == m_never_ch) ? -1 : m_delay;
        end else if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                cnv_cmplt = 1'b1;
                res = ((m_ch < 3'd4) ? m_lo : m_hi) + 12'(m_step * m_ch);
            end
        end
    end

    // ---------------- monitor ----------------
    int           strt_cyc_q[$];
    logic [2:0]   strt_ch_q[$];
    int           done_cnt  = 0;
    int           hold_viol = 0;
    logic [W-1:0] last_committed = '0;

    always @(negedge clk) begin
        if (strt_cnv) begin
            strt_cyc_q.push_back(cyc);
            strt_ch_q.push_back(chnnl);
        end
        if (scan_done) done_cnt++;
        // `sensors` may change only in the scan_done cycle.
        if (rst_n && busy && !scan_done && sensors !== last_committed) hold_viol++;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic clear_mon();
        strt_cyc_q.delete();
        strt_ch_q.delete();
        done_cnt  = 0;
        hold_viol = 0;
    endtask

    task automatic set_model(input int d, input logic [11:0] lo, input logic [11:0] hi,
                             input logic [11:0] step);
        m_delay = d;
        m_lo    = lo;
        m_hi    = hi;
        m_step  = step;
    endtask

    // ---------------- driver: one full scan with a single go pulse ----------------
    task automatic run_scan(input string tag, input int exp_done_off, input logic [W-1:0] exp_sens);
        int t0;
        int n;
        int first;
        logic ok;
        clear_mon();
        @(negedge clk);
        go = 1'b1;
        t0 = cyc;
        @(negedge clk);
        go = 1'b0;
        check({tag, " busy@1"}, W'(busy), W'(1));
        check({tag, " IR_en@1"}, W'(IR_en), W'(1));
        check({tag, " err_clr@1"}, W'(err), W'(0));
        n = 0;
        while (!scan_done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " done_cycle"}, W'(cyc - t0), W'(exp_done_off));
        check({tag, " sensors"}, sensors, exp_sens);
        check({tag, " err"}, W'(err), W'(0));
        check({tag, " strt_count"}, W'(strt_cyc_q.size()), W'(NUM_CH));
        first = (strt_cyc_q.size() > 0) ? strt_cyc_q[0] - t0 : -1;
        check({tag, " first_strt"}, W'(first), W'(SETTLE + 1));
        ok = (strt_ch_q.size() == NUM_CH);
        if (ok) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (strt_ch_q[i] != 3'(i)) ok = 1'b0;
            end
        end
        check({tag, " chan_order"}, W'(ok), W'(1));
        @(negedge clk);
        check({tag, " busy_after"}, W'(busy), W'(0));
        check({tag, " IR_en_after"}, W'(IR_en), W'(0));
        check({tag, " done_pulses"}, W'(done_cnt), W'(1));
        check({tag, " held_until_done"}, W'(hold_viol), W'(0));
        last_committed = exp_sens;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string        name;
        int           delay;
        logic [11:0]  lo;
        logic [11:0]  hi;
        logic [11:0]  step;
        int           done_off;   // go cycle -> scan_done cycle
        logic [W-1:0] exp_sens;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int t0;
        int n;
        int s3;

        // Channel i starts at 17 + i*(D+1) and is captured D cycles later.
        // scan_done follows the last capture, so done = 25 + 8*D.
        vecs[0] = '{"nominal", 40, 12'h100, 12'h100, 12'h001, 345,
                    96'h107_106_105_104_103_102_101_100};
        vecs[1] = '{"scan_aaa", 1, 12'hAAA, 12'hAAA, 12'h000, 33,
                    96'hAAA_AAA_AAA_AAA_AAA_AAA_AAA_AAA};
        vecs[2] = '{"scan_555", 5, 12'h555, 12'h123, 12'h000, 65,
                    96'h123_123_123_123_555_555_555_555};
        // D=64: every completion lands on the watchdog's last cycle.
        vecs[3] = '{"simultaneous", 64, 12'h0F0, 12'h0F0, 12'h100, 537,
                    96'h7F0_6F0_5F0_4F0_3F0_2F0_1F0_0F0};

        rst_n     = 1'b0;
        go        = 1'b0;
        cnv_cmplt = 1'b0;
        res       = '0;
        repeat (2) @(negedge clk);
        check("rst busy", W'(busy), W'(0));
        check("rst IR_en", W'(IR_en), W'(0));
        check("rst strt_cnv", W'(strt_cnv), W'(0));
        check("rst chnnl", W'(chnnl), W'(0));
        check("rst err", W'(err), W'(0));
        check("rst scan_done", W'(scan_done), W'(0));
        check("rst sensors", sensors, W'(0));
        rst_n = 1'b1;

        // ---- table-driven scans (the aaa -> 555 pair also checks the atomic commit) ----
        for (int v = 0; v < 4; v++) begin
            set_model(vecs[v].delay, vecs[v].lo, vecs[v].hi, vecs[v].step);
            run_scan(vecs[v].name, vecs[v].done_off, vecs[v].exp_sens);
        end

        // ---- timeout on ch3 ----
        // ch3 starts at 17 + 3*41 = 140. WAIT counts 0..63 over cycles
        // 141..204. The flag is registered, so it is first visible at 205.
        set_model(40, 12'h321, 12'h321, 12'h000);
        m_never_ch = 3;
        clear_mon();
        @(negedge clk);
        go = 1'b1;
        t0 = cyc;
        @(negedge clk);
        go = 1'b0;
        n = 0;
        while (!err && n < 1000) begin
            @(negedge clk);
            n++;
        end
        s3 = (strt_cyc_q.size() >= 4) ? strt_cyc_q[3] : -1000;
        check("to ch3_strt", W'(s3 - t0), W'(140));
        check("to err_cycle", W'(cyc - s3), W'(TIMEOUT + 1));
        check("to busy", W'(busy), W'(0));
        check("to IR_en", W'(IR_en), W'(0));
        check("to chnnl", W'(chnnl), W'(0));
        check("to strt_count", W'(strt_cyc_q.size()), W'(4));
        repeat (3) @(negedge clk);
        check("to err_sticky", W'(err), W'(1));
        check("to no_done", W'(done_cnt), W'(0));
        check("to sensors_kept", sensors, vecs[3].exp_sens);
        m_never_ch = -1;
        set_model(vecs[0].delay, vecs[0].lo, vecs[0].hi, vecs[0].step);
        run_scan("after_to", vecs[0].done_off, vecs[0].exp_sens);

        // ---- go held high through a whole scan ----
        set_model(1, 12'h3C3, 12'h3C3, 12'h000);
        clear_mon();
        @(negedge clk);
        go = 1'b1;
        t0 = cyc;
        n = 0;
        while (!scan_done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("held done_cycle", W'(cyc - t0), W'(33));
        check("held strt_count", W'(strt_cyc_q.size()), W'(NUM_CH));
        check("held sensors", sensors, 96'h3C3_3C3_3C3_3C3_3C3_3C3_3C3_3C3);
        last_committed = 96'h3C3_3C3_3C3_3C3_3C3_3C3_3C3_3C3;
        @(negedge clk);
        check("held idle busy", W'(busy), W'(0));
        check("held idle IR_en", W'(IR_en), W'(0));
        @(negedge clk);
        check("held restart busy", W'(busy), W'(1));
        check("held restart IR_en", W'(IR_en), W'(1));
        go = 1'b0;
        n = 0;
        while (!scan_done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("held second_done", W'(done_cnt), W'(2));
        check("held second_strts", W'(strt_cyc_q.size()), W'(2 * NUM_CH));
        check("held second_idle", W'(busy), W'(0));

        // ---- reset during the ch4 wait ----
        set_model(40, 12'h100, 12'h100, 12'h001);
        clear_mon();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n = 0;
        while (strt_cyc_q.size() < 5 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("rw pre chnnl", W'(chnnl), W'(4));
        check("rw pre busy", W'(busy), W'(1));
        rst_n = 1'b0;
        #1;
        check("rw busy", W'(busy), W'(0));
        check("rw IR_en", W'(IR_en), W'(0));
        check("rw chnnl", W'(chnnl), W'(0));
        check("rw strt_cnv", W'(strt_cnv), W'(0));
        check("rw scan_done", W'(scan_done), W'(0));
        check("rw err", W'(err), W'(0));
        check("rw sensors", sensors, W'(0));
        last_committed = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("rw late busy", W'(busy), W'(0));
        check("rw late strts", W'(strt_cyc_q.size()), W'(5));
        check("rw late done", W'(done_cnt), W'(0));
        check("rw late sensors", sensors, W'(0));
        check("rw late IR_en", W'(IR_en), W'(0));
        set_model(1, 12'hAAA, 12'hAAA, 12'h000);
        run_scan("after_rst", 33, 96'hAAA_AAA_AAA_AAA_AAA_AAA_AAA_AAA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
